// File: rtl/instructmem_loader.sv
// ============================================================================
// Module   : instructmem_loader
// Brief    : Packs a little-endian byte stream into 32-bit words and writes
//            them to instruction memory from byte address 0, one word per strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instructmem_loader #(
  parameter  int MEM_SIZE = 1024,
  localparam int CNT_W    = $clog2(MEM_SIZE / 4) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERR     = 3'd4;

  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(MEM_SIZE / 4);

  logic [2:0]       state_q,     state_d;
  logic [1:0]       byte_cnt_q,  byte_cnt_d;
  logic [CNT_W-1:0] word_cnt_q,  word_cnt_d;
  logic [CNT_W-1:0] num_words_q, num_words_d;
  logic [63:0]      addr_q,      addr_d;
  logic [23:0]      word_q,      word_d;
  logic [63:0]      wr_addr_q,   wr_addr_d;
  logic [31:0]      wr_data_q,   wr_data_d;

  logic w_start_ok;
  logic w_load_start;
  logic w_xfer;
  logic w_last_byte;
  logic w_last_word;

  assign w_start_ok   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_ERR));
  assign w_load_start = w_start_ok && (num_words != '0) && (num_words <= MAX_WORDS);
  assign w_xfer       = byte_valid && (state_q == ST_COLLECT);
  assign w_last_byte  = w_xfer && (byte_cnt_q == 2'd3);
  assign w_last_word  = ((word_cnt_q + CNT_W'(1)) == num_words_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (w_start_ok) begin
          if (num_words == '0) begin
            state_d = ST_DONE;
          end else if (num_words > MAX_WORDS) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        if (w_last_byte) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = w_last_word ? ST_DONE : ST_COLLECT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    byte_ready = (state_q == ST_COLLECT);
    wr_en      = (state_q == ST_WRITE);
    busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    done       = (state_q == ST_DONE);
    error      = (state_q == ST_ERR);
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // Datapath next-state: the fourth byte goes straight into the write register,
  // so the word buffer only needs to hold the first three.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    num_words_d = num_words_q;
    addr_d      = addr_q;
    word_d      = word_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    if (w_load_start) begin
      byte_cnt_d  = 2'd0;
      word_cnt_d  = '0;
      num_words_d = num_words;
      addr_d      = 64'd0;
      word_d      = 24'd0;
    end

    if (w_xfer) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      case (byte_cnt_q)
        2'd0:    word_d[7:0]   = byte_data;
        2'd1:    word_d[15:8]  = byte_data;
        2'd2:    word_d[23:16] = byte_data;
        default: begin
          wr_data_d = {byte_data, word_q};
          wr_addr_d = addr_q;
        end
      endcase
    end

    if ((state_q == ST_WRITE) && !w_last_word) begin
      addr_d     = addr_q + 64'd4;
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      addr_q      <= 64'd0;
      word_q      <= 24'd0;
      wr_addr_q   <= 64'd0;
      wr_data_q   <= 32'd0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      num_words_q <= num_words_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instructmem_loader.sv
// ============================================================================
// Module   : tb_instructmem_loader
// Brief    : Randomized self-checking bench; expected writes are derived from
//            the byte stream offered to the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instructmem_loader;

  localparam int MEM_SIZE = 1024;
  localparam int CNT_W    = $clog2(MEM_SIZE / 4) + 1;

  logic             clk        = 1'b0;
  logic             reset_n    = 1'b0;
  logic             start      = 1'b0;
  logic [CNT_W-1:0] num_words  = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data  = 8'd0;
  logic             byte_ready;
  logic             wr_en;
  logic [63:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             busy;
  logic             done;
  logic             error;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_xfer   = 0;
  logic [63:0] got_addr[$];
  logic [31:0] got_data[$];

  always #5 clk = ~clk;

  instructmem_loader #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // Record every write strobe and every handshake that will complete at the next edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (byte_valid && byte_ready) n_xfer++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int nw);
    start     = 1'b1;
    num_words = CNT_W'(nw);
    tick();
    start     = 1'b0;
    num_words = CNT_W'($urandom);
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    bit acc;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      acc = byte_ready;
      tick();
      if (acc) begin
        byte_valid = 1'b0;
        return;
      end
    end
    check("byte_accept_timeout", 64'd0, 64'd1);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done || error) break;
    end
    check("load_done", {63'd0, done}, 64'd1);
  endtask

  // incr=1 uses byte value (index mod 256); poke_at>=0 pulses start mid-load
  task automatic run_load(input int nw, input int max_gap, input bit incr, input int poke_at);
    int          base_w;
    int          base_x;
    logic [7:0]  bytes[$];
    logic [7:0]  b;
    logic [31:0] exp;
    base_w = got_addr.size();
    base_x = n_xfer;
    pulse_start(nw);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("error_after_start", {63'd0, error}, 64'd0);
    for (int i = 0; i < 4 * nw; i++) begin
      if (i == poke_at) pulse_start(1);
      b = incr ? 8'(i) : 8'($urandom);
      bytes.push_back(b);
      push_byte(b, (max_gap == 0) ? 0 : $urandom_range(0, max_gap));
    end
    wait_done();
    check("write_count", 64'(got_addr.size() - base_w), 64'(nw));
    check("byte_count", 64'(n_xfer - base_x), 64'(4 * nw));
    for (int i = 0; i < nw && base_w + i < got_addr.size(); i++) begin
      exp = 32'd0;
      for (int k = 0; k < 4; k++) exp = exp + (32'(bytes[4*i+k]) << (8 * k));
      check($sformatf("addr[%0d]", i), got_addr[base_w+i], 64'(4 * i));
      check($sformatf("data[%0d]", i), 64'(got_data[base_w+i]), 64'(exp));
    end
  endtask

  initial begin
    int base_w;
    int base_x;
    int nw;

    // Reset state
    #12;
    check("rst_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_wr_addr", wr_addr, 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Single word, exact timing
    base_w = got_addr.size();
    pulse_start(1);
    push_byte(8'h78, 0);
    push_byte(8'h56, 0);
    push_byte(8'h34, 0);
    push_byte(8'h12, 0);
    @(negedge clk);
    check("t1_wr_en", {63'd0, wr_en}, 64'd1);
    check("t1_addr", wr_addr, 64'd0);
    check("t1_data", 64'(wr_data), 64'h12345678);
    check("t1_ready_in_write", {63'd0, byte_ready}, 64'd0);
    check("t1_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    check("t1_wr_en_low", {63'd0, wr_en}, 64'd0);
    check("t1_done", {63'd0, done}, 64'd1);
    check("t1_busy_low", {63'd0, busy}, 64'd0);
    check("t1_writes", 64'(got_addr.size() - base_w), 64'd1);
    check("t1_data_hold", 64'(wr_data), 64'h12345678);
    tick();

    // Full memory, incrementing bytes
    base_w = got_addr.size();
    run_load(MEM_SIZE / 4, 0, 1'b1, -1);
    if (got_addr.size() == base_w + MEM_SIZE / 4) begin
      check("full_last_addr", got_addr[base_w+MEM_SIZE/4-1], 64'd1020);
      check("full_last_data", 64'(got_data[base_w+MEM_SIZE/4-1]), 64'hFFFEFDFC);
    end else begin
      check("full_count", 64'(got_addr.size() - base_w), 64'(MEM_SIZE / 4));
    end

    // Oversized count -> error, nothing consumed, then a legal start recovers
    base_w = got_addr.size();
    base_x = n_xfer;
    pulse_start(MEM_SIZE / 4 + 1);
    check("err_flag", {63'd0, error}, 64'd1);
    check("err_busy", {63'd0, busy}, 64'd0);
    check("err_ready", {63'd0, byte_ready}, 64'd0);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (3) tick();
    byte_valid = 1'b0;
    check("err_no_xfer", 64'(n_xfer - base_x), 64'd0);
    check("err_no_write", 64'(got_addr.size() - base_w), 64'd0);
    check("err_held", {63'd0, error}, 64'd1);
    run_load(2, 3, 1'b0, -1);

    // Random loads with gaps; bytes are held across the write cycle
    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(1, 6);
      run_load(nw, (r < 2) ? 0 : 3, 1'b0, -1);
    end

    // Async reset after two bytes of a word
    pulse_start(1);
    push_byte(8'hAA, 0);
    push_byte(8'hBB, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_ready", {63'd0, byte_ready}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_wr_addr", wr_addr, 64'd0);
    check("arst_wr_data", 64'(wr_data), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_load(1, 2, 1'b0, -1);

    // Zero words, then a start pulse while busy
    base_w = got_addr.size();
    pulse_start(0);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_busy", {63'd0, busy}, 64'd0);
    repeat (3) tick();
    check("zero_writes", 64'(got_addr.size() - base_w), 64'd0);
    run_load(3, 2, 1'b0, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
